// File: rtl/bru_pkg.sv
// Shared types for the execute-stage branch resolution unit and its BTB update FIFO.
package bru_pkg;

    localparam int unsigned BRU_XLEN = 32;

    typedef enum logic [1:0] {
        BR_COND = 2'b00,
        BR_JAL  = 2'b01,
        BR_JALR = 2'b10,
        BR_RSVD = 2'b11
    } br_kind_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } bru_state_e;

    typedef struct packed {
        logic [BRU_XLEN-1:0] pc;
        logic [BRU_XLEN-1:0] target;
        logic                taken;
    } btb_upd_t;

endpackage

// File: rtl/bru_upd_fifo.sv
// Synchronous FIFO of BTB update records; pointers wrap naturally since DEPTH is a power of two.
module bru_upd_fifo
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  btb_upd_t                   i_data,
    input  logic                       i_pop,
    output btb_upd_t                   o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    btb_upd_t        r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == (AW + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: redirects the frontend on mispredict and streams BTB training
// writes. Optional BRU_STATS_EN adds branch/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned UPD_DEPTH = 4,
    parameter int unsigned XLEN      = BRU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [1:0]      br_kind,
    input  logic [2:0]      br_funct3,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_rs1,
    input  logic [XLEN-1:0] br_rs2,
    input  logic [XLEN-1:0] br_imm,
    input  logic            br_pred_taken,
    input  logic [XLEN-1:0] br_pred_target,
    output logic            link_valid,
    output logic [XLEN-1:0] link_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            upd_en,
    output logic [XLEN-1:0] upd_pc,
    output logic [XLEN-1:0] upd_target,
    output logic            upd_taken,
    input  logic            upd_hold
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    bru_state_e                 r_state;
    bru_state_e                 w_state_next;
    br_kind_e                   w_kind;
    logic                       w_cond_taken;
    logic                       w_f3_ok;
    logic                       w_taken;
    logic [XLEN-1:0]            w_jalr_sum;
    logic [XLEN-1:0]            w_target;
    logic [XLEN-1:0]            w_pc4;
    logic                       w_mispred;
    logic                       w_accept;
    logic                       w_resolve;
    logic                       w_push;
    logic                       w_link;
    logic                       w_redir_set;
    logic                       r_link_valid;
    logic [XLEN-1:0]            r_link_data;
    logic [XLEN-1:0]            r_redirect_pc;
    btb_upd_t                   w_push_data;
    btb_upd_t                   w_head;
    logic                       w_full;
    logic                       w_empty;
    logic [$clog2(UPD_DEPTH):0] w_count;

    assign w_kind = br_kind_e'(br_kind);

    always_comb begin
        w_cond_taken = 1'b0;
        w_f3_ok      = 1'b1;
        case (br_funct3)
            F3_BEQ:  w_cond_taken = (br_rs1 == br_rs2);
            F3_BNE:  w_cond_taken = (br_rs1 != br_rs2);
            F3_BLT:  w_cond_taken = ($signed(br_rs1) < $signed(br_rs2));
            F3_BGE:  w_cond_taken = ($signed(br_rs1) >= $signed(br_rs2));
            F3_BLTU: w_cond_taken = (br_rs1 < br_rs2);
            F3_BGEU: w_cond_taken = (br_rs1 >= br_rs2);
            default: w_f3_ok      = 1'b0;
        endcase
    end

    assign w_jalr_sum = br_rs1 + br_imm;
    assign w_target   = (w_kind == BR_JALR) ? {w_jalr_sum[XLEN-1:1], 1'b0} : br_pc + br_imm;
    assign w_pc4      = br_pc + XLEN'(4);
    assign w_taken    = (w_kind == BR_JAL) || (w_kind == BR_JALR) ||
                        ((w_kind == BR_COND) && w_cond_taken);
    assign w_mispred  = (w_taken != br_pred_taken) || (w_taken && (br_pred_target != w_target));

    // Ready looks only at the registered occupancy; a same-cycle pop does not free a slot.
    assign br_ready = !rst && !w_full;
    assign w_accept = br_valid && br_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_redir_set) w_state_next = REDIRECT;
            REDIRECT: if (redirect_ready) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Anything accepted while a redirect is outstanding is wrong-path and gets dropped.
    always_comb begin
        w_resolve   = 1'b0;
        w_push      = 1'b0;
        w_link      = 1'b0;
        w_redir_set = 1'b0;
        if ((r_state == IDLE) && w_accept && (w_kind != BR_RSVD)) begin
            w_resolve   = 1'b1;
            w_push      = (w_kind != BR_COND) || w_f3_ok;
            w_link      = (w_kind == BR_JAL) || (w_kind == BR_JALR);
            w_redir_set = w_mispred;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_link_valid  <= 1'b0;
            r_link_data   <= '0;
            r_redirect_pc <= '0;
        end else begin
            r_link_valid <= w_link;
            if (w_link)      r_link_data   <= w_pc4;
            if (w_redir_set) r_redirect_pc <= w_taken ? w_target : w_pc4;
        end
    end

    assign link_valid     = r_link_valid;
    assign link_data      = r_link_data;
    assign redirect_valid = (r_state == REDIRECT);
    assign redirect_pc    = r_redirect_pc;

    assign w_push_data = '{pc: br_pc, target: w_target, taken: w_taken};

    bru_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (upd_en),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Head fields are masked while empty so stale storage never shows on the port.
    assign upd_en     = (w_count != '0) && !upd_hold;
    assign upd_pc     = w_empty ? '0 : w_head.pc;
    assign upd_target = w_empty ? '0 : w_head.target;
    assign upd_taken  = !w_empty && w_head.taken;

`ifdef BRU_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_resolve)   r_stat_branches <= r_stat_branches + 32'd1;
            if (w_redir_set) r_stat_mispred  <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table plus redirect, back-pressure and reset
// sequences.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid;
    logic        br_ready;
    logic [1:0]  br_kind;
    logic [2:0]  br_funct3;
    logic [31:0] br_pc, br_rs1, br_rs2, br_imm;
    logic        br_pred_taken;
    logic [31:0] br_pred_target;
    logic        link_valid;
    logic [31:0] link_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        upd_en;
    logic [31:0] upd_pc, upd_target;
    logic        upd_taken;
    logic        upd_hold;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [2:0]  f3;
        logic [31:0] pc, rs1, rs2, imm;
        logic        pt;
        logic [31:0] ptgt;
        logic        push;
        logic        taken;
        logic [31:0] tgt;
        logic        redir;
        logic [31:0] rpc;
        logic        link;
        logic [31:0] ldata;
    } vec_t;

    vec_t vecs[12];

    branch_resolve_unit #(
        .UPD_DEPTH (4),
        .XLEN      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_ready       (br_ready),
        .br_kind        (br_kind),
        .br_funct3      (br_funct3),
        .br_pc          (br_pc),
        .br_rs1         (br_rs1),
        .br_rs2         (br_rs2),
        .br_imm         (br_imm),
        .br_pred_taken  (br_pred_taken),
        .br_pred_target (br_pred_target),
        .link_valid     (link_valid),
        .link_data      (link_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .upd_en         (upd_en),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken),
        .upd_hold       (upd_hold)
`ifdef BRU_STATS_EN
        ,
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        br_valid       = 1'b1;
        br_kind        = v.kind;
        br_funct3      = v.f3;
        br_pc          = v.pc;
        br_rs1         = v.rs1;
        br_rs2         = v.rs2;
        br_imm         = v.imm;
        br_pred_taken  = v.pt;
        br_pred_target = v.ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " br_ready"}, {31'd0, br_ready}, 32'd0);
        check({tag, " link_valid"}, {31'd0, link_valid}, 32'd0);
        check({tag, " link_data"}, link_data, 32'd0);
        check({tag, " redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
        check({tag, " redirect_pc"}, redirect_pc, 32'd0);
        check({tag, " upd_en"}, {31'd0, upd_en}, 32'd0);
        check({tag, " upd_pc"}, upd_pc, 32'd0);
        check({tag, " upd_target"}, upd_target, 32'd0);
        check({tag, " upd_taken"}, {31'd0, upd_taken}, 32'd0);
    endtask

    initial begin
        vec_t  v;
        string s;

        // kind f3 pc rs1 rs2 imm pt ptgt | push taken tgt redir rpc link ldata
        vecs[0]  = '{2'b00, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120,
                     1'b1, 1'b1, 32'h120, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1]  = '{2'b00, 3'b001, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0,
                     1'b1, 1'b0, 32'h120, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[2]  = '{2'b00, 3'b101, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h240,
                     1'b1, 1'b0, 32'h240, 1'b1, 32'h204, 1'b0, 32'h0};
        vecs[3]  = '{2'b00, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0,
                     1'b1, 1'b0, 32'h240, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[4]  = '{2'b00, 3'b111, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h240,
                     1'b1, 1'b1, 32'h240, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[5]  = '{2'b01, 3'b000, 32'h400, 32'h0, 32'h0, 32'hFFFF_FFF0, 1'b1, 32'h3F0,
                     1'b1, 1'b1, 32'h3F0, 1'b0, 32'h0, 1'b1, 32'h404};
        vecs[6]  = '{2'b10, 3'b000, 32'h300, 32'h1003, 32'h0, 32'h0, 1'b1, 32'h1000,
                     1'b1, 1'b1, 32'h1002, 1'b1, 32'h1002, 1'b1, 32'h304};
        vecs[7]  = '{2'b00, 3'b000, 32'h500, 32'd7, 32'd7, 32'h8, 1'b1, 32'h600,
                     1'b1, 1'b1, 32'h508, 1'b1, 32'h508, 1'b0, 32'h0};
        vecs[8]  = '{2'b11, 3'b000, 32'h600, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0,
                     1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[9]  = '{2'b00, 3'b010, 32'h700, 32'd1, 32'd2, 32'h10, 1'b0, 32'h0,
                     1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[10] = '{2'b00, 3'b100, 32'hFFFF_FFF0, 32'd1, 32'd2, 32'h20, 1'b1, 32'h10,
                     1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[11] = '{2'b00, 3'b001, 32'h800, 32'd1, 32'd2, 32'h10, 1'b0, 32'h0,
                     1'b1, 1'b1, 32'h810, 1'b1, 32'h810, 1'b0, 32'h0};

        rst = 1'b1;
        br_valid = 1'b0;
        redirect_ready = 1'b0;
        upd_hold = 1'b0;
        drive(vecs[0]);
        br_valid = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        check("post-reset br_ready", {31'd0, br_ready}, 32'd1);

        // Table: each op resolved in IDLE with an idle BTB port and an always-ready frontend.
        redirect_ready = 1'b1;
        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v);
            tick();
            br_valid = 1'b0;
            s = $sformatf("vec%0d", i);
            check({s, " upd_en"}, {31'd0, upd_en}, {31'd0, v.push});
            if (v.push) begin
                check({s, " upd_pc"}, upd_pc, v.pc);
                check({s, " upd_target"}, upd_target, v.tgt);
                check({s, " upd_taken"}, {31'd0, upd_taken}, {31'd0, v.taken});
            end
            check({s, " redirect_valid"}, {31'd0, redirect_valid}, {31'd0, v.redir});
            if (v.redir) check({s, " redirect_pc"}, redirect_pc, v.rpc);
            check({s, " link_valid"}, {31'd0, link_valid}, {31'd0, v.link});
            if (v.link) check({s, " link_data"}, link_data, v.ldata);
            tick();
            check({s, " drained"}, {31'd0, upd_en}, 32'd0);
            check({s, " redirect cleared"}, {31'd0, redirect_valid}, 32'd0);
        end

        // BLT mispredict held three cycles while wrong-path ops are dropped.
        redirect_ready = 1'b0;
        v = '{2'b00, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0,
              1'b1, 1'b1, 32'h240, 1'b1, 32'h240, 1'b0, 32'h0};
        drive(v);
        tick();
        check("blt redirect_valid c1", {31'd0, redirect_valid}, 32'd1);
        check("blt redirect_pc c1", redirect_pc, 32'h240);
        check("blt own upd_en", {31'd0, upd_en}, 32'd1);
        check("blt own upd_pc", upd_pc, 32'h200);
        check("blt own upd_target", upd_target, 32'h240);
        drive(vecs[0]);
        tick();
        check("wrongpath1 redirect_pc", redirect_pc, 32'h240);
        check("wrongpath1 redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("wrongpath1 upd_en", {31'd0, upd_en}, 32'd0);
        drive(vecs[5]);
        tick();
        check("wrongpath2 redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("wrongpath2 redirect_pc", redirect_pc, 32'h240);
        check("wrongpath2 upd_en", {31'd0, upd_en}, 32'd0);
        check("wrongpath2 link_valid", {31'd0, link_valid}, 32'd0);
        drive(vecs[6]);
        redirect_ready = 1'b1;
        tick();
        br_valid = 1'b0;
        redirect_ready = 1'b0;
        check("ready-cycle op redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("ready-cycle op upd_en", {31'd0, upd_en}, 32'd0);
        check("ready-cycle op link_valid", {31'd0, link_valid}, 32'd0);

        // Back-pressure: four accepts fill the FIFO, the fifth waits for a drain.
        upd_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = vecs[0];
            v.pc = 32'h1000 + 32'(i * 16);
            v.ptgt = v.pc + 32'h20;
            drive(v);
            check($sformatf("fill%0d br_ready", i), {31'd0, br_ready}, 32'd1);
            tick();
        end
        v = vecs[0];
        v.pc = 32'h1040;
        v.ptgt = 32'h1060;
        drive(v);
        check("full br_ready", {31'd0, br_ready}, 32'd0);
        check("hold upd_en", {31'd0, upd_en}, 32'd0);
        tick();
        tick();
        check("full held br_ready", {31'd0, br_ready}, 32'd0);
        upd_hold = 1'b0;
        #1;
        check("release upd_en", {31'd0, upd_en}, 32'd1);
        check("release upd_pc0", upd_pc, 32'h1000);
        check("release br_ready", {31'd0, br_ready}, 32'd0);
        tick();
        check("drain upd_pc1", upd_pc, 32'h1010);
        check("drain br_ready", {31'd0, br_ready}, 32'd1);
        tick();
        br_valid = 1'b0;
        for (int i = 2; i < 5; i++) begin
            check($sformatf("drain%0d upd_en", i), {31'd0, upd_en}, 32'd1);
            check($sformatf("drain%0d upd_pc", i), upd_pc, 32'h1000 + 32'(i * 16));
            check($sformatf("drain%0d upd_target", i), upd_target, 32'h1020 + 32'(i * 16));
            tick();
        end
        check("drained upd_en", {31'd0, upd_en}, 32'd0);

        // Reset while a redirect is pending and two updates are queued.
        upd_hold = 1'b1;
        drive(vecs[0]);
        tick();
        drive(vecs[11]);
        tick();
        br_valid = 1'b0;
        check("pre-rst redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("pre-rst redirect_pc", redirect_pc, 32'h810);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid-rst");
        @(negedge clk);
        rst = 1'b0;
        upd_hold = 1'b0;
        tick();
        check("after-rst upd_en", {31'd0, upd_en}, 32'd0);
        check("after-rst redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("after-rst br_ready", {31'd0, br_ready}, 32'd1);
        tick();
        check("after-rst upd_en 2", {31'd0, upd_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
